counter_4bit_down_reload: RTL and testbench
===========================================

COUNTER_4BIT_DOWN_RELOAD -- requirements
Module: counter_4bit_down_reload

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the counter and load-value width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the posedge.
REQ-003 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port load, input, 1 bit: when high, capture load_val; takes priority over en.
REQ-005 SHALL have port load_val, input, WIDTH bits: start/reload value.
REQ-006 SHALL have port en, input, 1 bit: count enable (decrement strobe).
REQ-007 SHALL have port auto_reload, input, 1 bit: 1 selects periodic mode; 0 selects one-shot mode.
REQ-008 SHALL have port q, output, WIDTH bits: current count, registered.
REQ-009 SHALL have port tc, output, 1 bit: terminal-count pulse, registered, high exactly one cycle.
REQ-010 SHALL have port busy, output, 1 bit: high while in RUN.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE, plus an internal WIDTH-bit reload register rl.
REQ-012 SHALL, on any cycle with load=1 in any state, set rl<=load_val and q<=load_val, with tc<=0.
REQ-013 SHALL, on such a load, go to RUN if load_val!=0, and to DONE if load_val==0 (no tc pulse).
REQ-014 SHALL, in RUN with en=0 and load=0, hold q.
REQ-015 SHALL, in RUN with en=1 and q>1, set q<=q-1.
REQ-016 SHALL, in RUN with en=1 and q==1, set q<=0 and tc<=1, so tc is high in the same cycle that q first reads 0.
REQ-017 SHALL, at the q==1 decrement, sample auto_reload: 1 stays in RUN; 0 goes to DONE.
REQ-018 SHALL, in RUN with en=1 and q==0 (periodic mode only), set q<=rl with no tc, giving a period of rl+1 enabled cycles.
REQ-019 SHALL keep q==0 in DONE and keep q held in IDLE; both states ignore en and wait for load.
REQ-020 SHALL treat a load in RUN as a restart that suppresses any tc pending that cycle.
REQ-021 SHALL change rl only via load; changing load_val without load has no effect.
REQ-022 SHALL never wrap q below 0; decrement happens only when q>=1.
REQ-023 SHALL drive busy=1 iff the state is RUN; busy is registered/state-decoded with no combinational path from inputs.

Reset
REQ-024 SHALL, on rstn=0 (asynchronous), force state=IDLE, q=0, rl=0, tc=0 and busy=0.
REQ-025 SHALL, on reset mid-count, abandon the count immediately with no tc pulse; the first load after release behaves per REQ-012/013.

Structure
REQ-026 SHALL place the state enum type (IDLE/RUN/DONE) and the default WIDTH constant in shared package counter_pkg.
REQ-027 SHALL use no sub-module; a single always block for the registers plus next-state logic suffices.

Verification
REQ-028 SHALL cover one-shot: load_val=3, auto_reload=0, en=1 continuous -> q=3,2,1,0; tc=1 only when q=0; then state DONE, busy=0, q holds 0.
REQ-029 SHALL cover periodic: load_val=2, auto_reload=1, en=1 -> q=2,1,0,2,1,0...; tc pulses every 3 cycles; busy stays 1.
REQ-030 SHALL cover gating: load_val=4 with en toggled 1,0,1,0,... -> q decrements only on en=1 cycles; tc after 4 enabled cycles.
REQ-031 SHALL cover reload-at-terminal: load=1 with load_val=5 on the cycle where q==1 and en=1 -> q=5, tc=0, state RUN.
REQ-032 SHALL cover zero load: load_val=0 -> q=0, DONE, tc never asserted, busy=0.
REQ-033 SHALL cover reset mid-count: rstn pulled low asynchronously at q=2 -> q=0, tc=0, busy=0 before the next clk edge.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state type and default width for the reload down-counter
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : counter_pkg

// File: rtl/counter_4bit_down_reload.sv
// rtl/counter_4bit_down_reload.sv - loadable down-counter with one-shot/periodic terminal-count pulse
module counter_4bit_down_reload
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rl_q, rl_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  // Next-state: load restarts from any state; RUN counts down and either reloads or parks in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rl_d    = rl_q;
    tc_d    = 1'b0;

    if (load) begin
      // A load wins over en, so any terminal count due this cycle is dropped.
      rl_d    = load_val;
      cnt_d   = load_val;
      state_d = (load_val != ZERO) ? RUN : DONE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (en) begin
            if (cnt_q > ONE) begin
              cnt_d = cnt_q - ONE;
            end else if (cnt_q == ONE) begin
              cnt_d   = ZERO;
              tc_d    = 1'b1;
              state_d = auto_reload ? RUN : DONE;
            end else begin
              // q==0 in RUN only follows a periodic terminal count: reload silently.
              cnt_d = rl_q;
            end
          end
        end
        DONE: begin
          cnt_d = ZERO;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end

    // busy comes from the next state so it is a plain flop output, aligned with state_q.
    busy_d = (state_d == RUN);
  end

  // Register file for state, count, reload value and the registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= ZERO;
      rl_q    <= ZERO;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rl_q    <= rl_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  assign q    = cnt_q;
  assign tc   = tc_q;
  assign busy = busy_q;

endmodule : counter_4bit_down_reload

// File: tb/tb_counter_4bit_down_reload.sv
// tb/tb_counter_4bit_down_reload.sv - directed self-checking bench for the reload down-counter
module tb_counter_4bit_down_reload;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rstn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  int n_checks;
  int n_errors;

  counter_4bit_down_reload #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .q           (q),
    .tc          (tc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // One clock: inputs were set at a negedge, outputs sampled at the next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input int eq, input int etc, input int ebusy);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".tc"}, 32'(tc), 32'(etc));
    check({tag, ".busy"}, 32'(busy), 32'(ebusy));
  endtask

  // Gating pattern: en per cycle, expected q and tc after that cycle.
  int gate_en [7] = '{1, 0, 1, 0, 1, 0, 1};
  int gate_q  [7] = '{3, 3, 2, 2, 1, 1, 0};
  int gate_tc [7] = '{0, 0, 0, 0, 0, 0, 1};

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rstn        = 1'b0;
    load        = 1'b0;
    load_val    = '0;
    en          = 1'b0;
    auto_reload = 1'b0;

    // Reset state
    @(negedge clk);
    expect_out("reset", 0, 0, 0);
    step();
    rstn = 1'b1;

    // IDLE ignores en
    en = 1'b1;
    step();
    expect_out("idle_en", 0, 0, 0);

    // One-shot: 3,2,1,0 with tc on 0, then DONE holding 0
    load = 1'b1; load_val = 4'd3; auto_reload = 1'b0; en = 1'b1;
    step();
    expect_out("os_load", 3, 0, 1);
    load = 1'b0;
    step(); expect_out("os_2", 2, 0, 1);
    step(); expect_out("os_1", 1, 0, 1);
    step(); expect_out("os_0", 0, 1, 0);
    step(); expect_out("os_done0", 0, 0, 0);
    step(); expect_out("os_done1", 0, 0, 0);

    // Periodic: 2,1,0,2,1,0,2 with tc every 3 cycles, busy held
    load = 1'b1; load_val = 4'd2; auto_reload = 1'b1; en = 1'b1;
    step();
    expect_out("per_load", 2, 0, 1);
    load = 1'b0;
    step(); expect_out("per_1a", 1, 0, 1);
    step(); expect_out("per_0a", 0, 1, 1);
    step(); expect_out("per_2b", 2, 0, 1);
    step(); expect_out("per_1b", 1, 0, 1);
    step(); expect_out("per_0b", 0, 1, 1);
    step(); expect_out("per_2c", 2, 0, 1);

    // Gating: load 4, en alternating; tc after the 4th enabled cycle
    load = 1'b1; load_val = 4'd4; auto_reload = 1'b0; en = 1'b0;
    step();
    expect_out("gate_load", 4, 0, 1);
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en = gate_en[i][0];
      step();
      check($sformatf("gate_q%0d", i), 32'(q), 32'(gate_q[i]));
      check($sformatf("gate_tc%0d", i), 32'(tc), 32'(gate_tc[i]));
    end
    check("gate_busy_end", 32'(busy), 32'd0);

    // Reload at terminal: load 5 on the q==1 cycle suppresses tc
    load = 1'b1; load_val = 4'd2; auto_reload = 1'b0; en = 1'b1;
    step();
    load = 1'b0;
    step();
    expect_out("rat_pre", 1, 0, 1);
    load = 1'b1; load_val = 4'd5;
    step();
    expect_out("rat_load", 5, 0, 1);

    // load_val change without load leaves rl alone; periodic reload returns 5
    load = 1'b0; load_val = 4'd9; en = 1'b0; auto_reload = 1'b1;
    step();
    expect_out("rl_hold", 5, 0, 1);
    en = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      step();
      check($sformatf("rl_cnt%0d", i), 32'(q), 32'(i));
      check($sformatf("rl_tc%0d", i), 32'(tc), (i == 0) ? 32'd1 : 32'd0);
    end
    step();
    expect_out("rl_reload", 5, 0, 1);

    // Zero load: straight to DONE, no tc
    load = 1'b1; load_val = 4'd0;
    step();
    expect_out("zero_load", 0, 0, 0);
    load = 1'b0; en = 1'b1;
    step();
    expect_out("zero_hold", 0, 0, 0);

    // Reset mid-count at q=2: outputs clear before the next edge
    load = 1'b1; load_val = 4'd4; auto_reload = 1'b0; en = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    expect_out("mid_pre", 2, 0, 1);
    #2 rstn = 1'b0;
    #1;
    expect_out("mid_rst", 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    expect_out("mid_idle", 0, 0, 0);

    // First load after reset behaves normally
    load = 1'b1; load_val = 4'd1;
    step();
    expect_out("post_load", 1, 0, 1);
    load = 1'b0;
    step();
    expect_out("post_tc", 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_counter_4bit_down_reload
